exec_sequencer: RTL
===================

// Module: exec_sequencer
// PURPOSE
//  Multi-cycle control FSM for the 8-bit core. Accepts one instruction word per
//  fetch handshake and sequences the single-port register file (4 x 8-bit) and
//  the ALU through the read, execute and writeback steps. Pulses pc_inc to retire
//  each instruction. Replaces the cycle-count style of control with explicit states.
// PARAMETERS
//  DATA_W       8    register/ALU data width
//  ALU_TIMEOUT  16   max cycles in WAIT_ALU before the instruction is aborted (>=2)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       async reset, active-high
//  instr_valid  in   1       instr is valid
//  instr        in   8       [7:4] opcode, [3:2] rd/rs1, [1:0] rs2/imm
//  instr_ready  out  1       sequencer accepts instr this cycle
//  rf_en        out  1       register file access strobe
//  rf_we        out  1       1 = write, 0 = read (qualified by rf_en)
//  rf_addr      out  2       register index
//  rf_wdata     out  DATA_W  write data
//  rf_rdata     in   DATA_W  read data, valid the cycle after a read strobe
//  alu_start    out  1       one-cycle start pulse
//  alu_op       out  4       = ir[7:4]; held stable from EXEC until ALU completes
//  alu_a        out  DATA_W  operand A; held stable from EXEC until ALU completes
//  alu_b        out  DATA_W  operand B; held stable from EXEC until ALU completes
//  alu_done     in   1       result valid
//  alu_result   in   DATA_W  ALU result
//  pc_inc       out  1       one-cycle PC increment pulse
//  halted       out  1       high while in HALT
//  resume       in   1       leaves HALT
//  err_timeout  out  1       sticky ALU timeout flag, cleared only by rst
// BEHAVIOUR
//  - Instruction classes: 0x0-0x2 NOP; 0x3 HLT.
//    RR class: 0x4,0x5,0x6,0x7,0x8,0xA. A = R[ir[1:0]], B = R[ir[3:2]].
//    RI class: 0x9,0xB,0xC,0xD,0xE,0xF. A = R[ir[3:2]], B = {{6{ir[1]}},ir[1:0]}.
//    Compare ops 0x7 and 0xF produce no writeback. All others write R[ir[3:2]].
//  - States: IDLE, FETCH, RD_A, RD_B, CAP_B, EXEC, WAIT_ALU, WB, RETIRE, HALT.
//  - rst (any time, including mid-instruction): state=IDLE; ir, a_q, b_q, res_q
//    and the timeout counter clear to 0. All outputs are 0, including err_timeout.
//  - IDLE -> FETCH unconditionally.
//  - FETCH: instr_ready=1. On instr_valid, latch ir and branch:
//    NOP -> RETIRE; HLT -> HALT; RR/RI -> RD_A. With no valid, stay in FETCH.
//  - RD_A: rf_en=1, rf_we=0. rf_addr = ir[1:0] (RR) or ir[3:2] (RI).
//  - RD_B: a_q <= rf_rdata.
//    RR: issue read of ir[3:2], go to CAP_B.
//    RI: b_q <= sign-extended immediate, go to EXEC.
//  - CAP_B: b_q <= rf_rdata, go to EXEC.
//  - EXEC: alu_start=1 for exactly one cycle; alu_a=a_q, alu_b=b_q; go to WAIT_ALU.
//  - WAIT_ALU: alu_done is sampled from the first WAIT_ALU cycle onward.
//    alu_done in EXEC is ignored. The counter increments each cycle.
//    On done: res_q <= alu_result; go to RETIRE (compare) or WB.
//    On ALU_TIMEOUT cycles without done: set err_timeout, skip WB, go to RETIRE.
//  - WB: rf_en=1, rf_we=1, rf_addr=ir[3:2], rf_wdata=res_q.
//  - RETIRE: pc_inc=1 for one cycle, then FETCH.
//  - HALT: halted=1, instr_ready=0. On resume -> RETIRE (PC steps past HLT).
//  - Minimum latency, FETCH accept through RETIRE inclusive:
//    NOP 2; RR write 8; RR compare 7; RI write 7; RI compare 6 cycles.
//  - rf_en is never asserted outside RD_A, RD_B (RR only) and WB.
//    At most one instruction is in flight.
// TESTING
//  1. R1=0x05, R2=0x03, instr 0x46 (RR, rd=R1, rs2=R2), done on first WAIT cycle
//     -> alu_a=0x03, alu_b=0x05, WB writes R1 with alu_result, pc_inc 8 cycles
//     after accept.
//  2. instr 0xC7 (RI, rd=R1, imm=2'b11) -> alu_b=0xFF, alu_a=R1, single rf read,
//     WB to R1, pc_inc after 7 cycles.
//  3. instr 0x79 then 0xF6 (compare ops) -> no rf_we pulse; pc_inc after 7 and
//     6 cycles respectively.
//  4. instr 0x30, then resume pulsed 5 cycles later -> halted=1 and instr_ready=0
//     until resume; one pc_inc; then FETCH.
//  5. alu_done held low with ALU_TIMEOUT=16 -> err_timeout=1 after 16 WAIT cycles,
//     no writeback, pc_inc, next instr accepted; err_timeout stays 1.
//  6. rst asserted during WAIT_ALU -> all outputs 0 immediately; IDLE then FETCH
//     after release; the aborted instr produces no WB and no pc_inc.

Source files
------------

// File: rtl/exec_sequencer.sv
// -----------------------------------------------------------------------------
// exec_sequencer
// Multi-cycle control FSM for the 8-bit core. Takes one instruction per fetch
// handshake, then walks the single-port register file and the ALU through the
// read, execute and writeback steps. Each instruction retires with a one-cycle
// pc_inc pulse. Only one instruction is ever in flight.
//
// Handshakes:
//   fetch : an instruction transfers on a rising edge where instr_valid and
//           instr_ready are both high; instr_ready is high only in FETCH.
//   alu   : alu_start is a one-cycle pulse; alu_op/alu_a/alu_b stay stable
//           until alu_done is seen or the wait times out. alu_done is only
//           looked at from the first WAIT_ALU cycle onward.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   instr_valid/instr instruction word ([7:4] op, [3:2] rd/rs1, [1:0] rs2/imm)
//   instr_ready       sequencer accepts instr this cycle
//   rf_en/rf_we       register file strobe / write select
//   rf_addr/rf_wdata  register index / write data
//   rf_rdata          read data, valid the cycle after a read strobe
//   alu_start         one-cycle ALU start pulse
//   alu_op/a/b        ALU opcode and operands (driven in EXEC and WAIT_ALU)
//   alu_done/result   ALU completion and result
//   pc_inc            one-cycle PC increment pulse (RETIRE)
//   halted/resume     high in HALT / leaves HALT
//   err_timeout       sticky ALU timeout flag, cleared only by rst
//   state_dbg         current FSM state encoding
// -----------------------------------------------------------------------------
module exec_sequencer #(
  parameter int DATA_W      = 8,
  parameter int ALU_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [7:0]        instr,
  output logic              instr_ready,
  output logic              rf_en,
  output logic              rf_we,
  output logic [1:0]        rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              alu_start,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  output logic              pc_inc,
  output logic              halted,
  input  logic              resume,
  output logic              err_timeout,
  output logic [3:0]        state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_RD_A     = 4'd2,
    S_RD_B     = 4'd3,
    S_CAP_B    = 4'd4,
    S_EXEC     = 4'd5,
    S_WAIT_ALU = 4'd6,
    S_WB       = 4'd7,
    S_RETIRE   = 4'd8,
    S_HALT     = 4'd9
  } state_t;

  localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

  // Opcode classes
  function automatic logic op_is_nop(input logic [3:0] op);
    return (op <= 4'h2);
  endfunction

  function automatic logic op_is_hlt(input logic [3:0] op);
    return (op == 4'h3);
  endfunction

  // RI ops: 9, B..F. Everything from 4 upward that is not RI is RR.
  function automatic logic op_is_ri(input logic [3:0] op);
    return (op == 4'h9) || (op >= 4'hB);
  endfunction

  function automatic logic op_is_cmp(input logic [3:0] op);
    return (op == 4'h7) || (op == 4'hF);
  endfunction

  state_t            state, state_n;
  logic [7:0]        ir;
  logic [DATA_W-1:0] a_q, b_q, res_q;
  logic [CNT_W-1:0]  cnt;

  logic ir_ld, a_ld, b_ld_rf, b_ld_imm, res_ld, cnt_inc, err_set;
  logic ir_ri, ir_cmp;
  logic [DATA_W-1:0] imm_ext;

  assign ir_ri     = op_is_ri(ir[7:4]);
  assign ir_cmp    = op_is_cmp(ir[7:4]);
  assign imm_ext   = {{(DATA_W-2){ir[1]}}, ir[1:0]};
  assign state_dbg = state;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ir          <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cnt         <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_n;
      if (ir_ld)    ir    <= instr;
      if (a_ld)     a_q   <= rf_rdata;
      if (b_ld_rf)  b_q   <= rf_rdata;
      if (b_ld_imm) b_q   <= imm_ext;
      if (res_ld)   res_q <= alu_result;
      // The counter only runs while waiting on the ALU; any other cycle
      // leaves it at zero so each wait starts from a clean count.
      if (cnt_inc) cnt <= cnt + 1'b1;
      else         cnt <= '0;
      if (err_set) err_timeout <= 1'b1;
    end
  end

  // Next state and outputs
  always_comb begin
    state_n     = state;
    instr_ready = 1'b0;
    rf_en       = 1'b0;
    rf_we       = 1'b0;
    rf_addr     = 2'b00;
    rf_wdata    = '0;
    alu_start   = 1'b0;
    alu_op      = 4'h0;
    alu_a       = '0;
    alu_b       = '0;
    pc_inc      = 1'b0;
    halted      = 1'b0;
    ir_ld       = 1'b0;
    a_ld        = 1'b0;
    b_ld_rf     = 1'b0;
    b_ld_imm    = 1'b0;
    res_ld      = 1'b0;
    cnt_inc     = 1'b0;
    err_set     = 1'b0;

    case (state)
      S_IDLE: state_n = S_FETCH;

      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_ld = 1'b1;
          if (op_is_nop(instr[7:4]))      state_n = S_RETIRE;
          else if (op_is_hlt(instr[7:4])) state_n = S_HALT;
          else                            state_n = S_RD_A;
        end
      end

      // First read: rs2 for RR, rd/rs1 for RI
      S_RD_A: begin
        rf_en   = 1'b1;
        rf_addr = ir_ri ? ir[3:2] : ir[1:0];
        state_n = S_RD_B;
      end

      // Operand A arrives now; RR overlaps the second read with the capture.
      S_RD_B: begin
        a_ld = 1'b1;
        if (ir_ri) begin
          b_ld_imm = 1'b1;
          state_n  = S_EXEC;
        end else begin
          rf_en   = 1'b1;
          rf_addr = ir[3:2];
          state_n = S_CAP_B;
        end
      end

      S_CAP_B: begin
        b_ld_rf = 1'b1;
        state_n = S_EXEC;
      end

      S_EXEC: begin
        alu_start = 1'b1;
        alu_op    = ir[7:4];
        alu_a     = a_q;
        alu_b     = b_q;
        state_n   = S_WAIT_ALU;
      end

      S_WAIT_ALU: begin
        alu_op = ir[7:4];
        alu_a  = a_q;
        alu_b  = b_q;
        if (alu_done) begin
          res_ld  = 1'b1;
          state_n = ir_cmp ? S_RETIRE : S_WB;
        end else if (cnt == CNT_LAST) begin
          // Abort: flag it and retire without writing anything back.
          err_set = 1'b1;
          state_n = S_RETIRE;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      S_WB: begin
        rf_en    = 1'b1;
        rf_we    = 1'b1;
        rf_addr  = ir[3:2];
        rf_wdata = res_q;
        state_n  = S_RETIRE;
      end

      S_RETIRE: begin
        pc_inc  = 1'b1;
        state_n = S_FETCH;
      end

      // Resume retires the HLT itself so the PC steps past it.
      S_HALT: begin
        halted = 1'b1;
        if (resume) state_n = S_RETIRE;
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule
